// File: rtl/parking_pkg.sv
// Shared types and constants for the car direction detector.
// The state enum and the default debounce length live here.
package parking_pkg;

    localparam int unsigned DbCyclesDefault = 20;

    typedef enum logic [2:0] {
        StIdle,
        StIn1,
        StIn2,
        StIn3,
        StOut1,
        StOut2,
        StOut3
    } state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a debouncer for one photo sensor.
// The level flips only after DB_CYCLES consecutive disagreeing synchronized samples.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // Any agreeing sample falls through with cnt_d = 0, restarting the run.
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/car_direction_detector.sv
// Parking-lot gate direction detector: debounces two beam sensors and tracks the
// blocking order to emit one inc pulse per entry and one dec pulse per exit.
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec
);

    logic       a_db, b_db;
    logic [1:0] ab;
    state_e     state_q, state_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;

    sensor_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_deb_a (
        .clk_i   (clk),
        .rst_i   (reset),
        .raw_i   (a),
        .level_o (a_db)
    );

    sensor_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_deb_b (
        .clk_i   (clk),
        .rst_i   (reset),
        .raw_i   (b),
        .level_o (b_db)
    );

    assign ab = {a_db, b_db};

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // 11 from idle is ambiguous and deliberately ignored.
                if (ab == 2'b10) begin
                    state_d = StIn1;
                end else if (ab == 2'b01) begin
                    state_d = StOut1;
                end
            end
            StIn1: begin
                case (ab)
                    2'b11:   state_d = StIn2;
                    2'b10:   state_d = StIn1;
                    default: state_d = StIdle;
                endcase
            end
            StIn2: begin
                case (ab)
                    2'b01:   state_d = StIn3;
                    2'b10:   state_d = StIn1;
                    2'b11:   state_d = StIn2;
                    default: state_d = StIdle;
                endcase
            end
            StIn3: begin
                case (ab)
                    2'b00: begin
                        state_d = StIdle;
                        inc_d   = 1'b1;
                    end
                    2'b11:   state_d = StIn2;
                    2'b01:   state_d = StIn3;
                    default: state_d = StIdle;
                endcase
            end
            StOut1: begin
                case (ab)
                    2'b11:   state_d = StOut2;
                    2'b01:   state_d = StOut1;
                    default: state_d = StIdle;
                endcase
            end
            StOut2: begin
                case (ab)
                    2'b10:   state_d = StOut3;
                    2'b01:   state_d = StOut1;
                    2'b11:   state_d = StOut2;
                    default: state_d = StIdle;
                endcase
            end
            StOut3: begin
                case (ab)
                    2'b00: begin
                        state_d = StIdle;
                        dec_d   = 1'b1;
                    end
                    2'b11:   state_d = StOut2;
                    2'b10:   state_d = StOut3;
                    default: state_d = StIdle;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;

endmodule
